dmem_dump_responder: RTL and testbench
======================================

Name: dmem_dump_responder

Overview:
Data-memory responder at the far end of the processor_arm data-memory port (DM_addr / DM_writeData / DM_writeEnable).
- Services processor loads and stores.
- On a dump request, streams every memory word out over a valid/ready channel so benches and debug logic can capture final memory state.
- Replaces ad-hoc memory peeking in processor benches with a defined dump protocol.

Parameters:
N, 64, data and address width in bits
DEPTH, 64, number of N-bit words
ADDR_LSB, 3, byte-offset bits dropped from DM_addr (word = DM_addr[ADDR_LSB +: log2(DEPTH)])

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
DM_addr  in  N  byte address from processor
DM_writeData  in  N  store data
DM_writeEnable  in  1  store strobe, sampled on rising edge
DM_readEnable  in  1  load strobe
DM_readData  out  N  load data, combinational
dump  in  1  dump request, level; rising edge starts a dump
dump_data  out  N  word being streamed
dump_index  out  log2(DEPTH)  word index of dump_data
dump_valid  out  1  dump_data/dump_index valid
dump_ready  in  1  consumer accepts the current word
dump_done  out  1  one-cycle pulse after the last word is accepted
busy  out  1  high while dump is in progress
wr_dropped  out  1  sticky: a store arrived during a dump

Behaviour:
- Reset (reset=0, asynchronous): all memory words = 0, FSM = IDLE, dump_valid=0, dump_done=0, busy=0, wr_dropped=0, dump_index=0, dump_data=0, dump edge detector cleared (dump_q=0).
- Address decode: widx = DM_addr >> ADDR_LSB. Bits below ADDR_LSB are ignored (misaligned address behaves as aligned). widx >= DEPTH is out of range.
- Loads: DM_readData = mem[widx] when DM_readEnable=1 and in range, else 0. Purely combinational, zero latency, so the single-cycle processor closes timing in one cycle.
- Stores: when DM_writeEnable=1, in range and FSM=IDLE, mem[widx] <= DM_writeData on the rising edge. Out-of-range stores are ignored.
- Load and store to the same address in the same cycle: load returns the old value. The new value is visible the next cycle.
- Dump start: dump_q registers dump. A start is dump=1 && dump_q=0 while FSM=IDLE. Holding dump high does not retrigger. A dump edge while not IDLE is ignored.
- FSM states:
  - IDLE: busy=0. On start, load ptr=0, dump_data<=mem[0], dump_index<=0, dump_valid<=1, go to STREAM. First word is valid the cycle after the edge.
  - STREAM: busy=1. dump_data/dump_index are held stable while dump_valid=1 && dump_ready=0. On handshake (dump_valid && dump_ready):
    - ptr<DEPTH-1: ptr<=ptr+1 and the next word is loaded the same edge, giving back-to-back throughput of one word per cycle.
    - ptr==DEPTH-1: dump_valid<=0 and go to DONE.
  - DONE: busy=1, dump_done=1 for exactly one cycle, then IDLE.
- Stores during STREAM or DONE: blocked so the dump is a consistent snapshot, and wr_dropped<=1. wr_dropped clears only on reset.
- Loads stay serviced in every state.
- dump_ready while dump_valid=0 has no effect.
- Reset asserted mid-dump: immediate return to IDLE, dump_valid=0, memory cleared. No dump_done pulse.
- Pointer arithmetic: ptr is log2(DEPTH) bits. Termination is by explicit compare against DEPTH-1, never by wrap-around.

Decomposition:
- Shared package dmem_pkg:
  - FSM enum typedef dump_state_t {IDLE, STREAM, DONE}
  - localparams DMEM_N=64, DMEM_DEPTH=64, DMEM_ADDR_LSB=3
  - function widx_of(addr)
- One sub-module, dmem_array: storage with async clear, one combinational read port, one write port.
- Dump FSM and pointer stay in the top level, which drives a second combinational read port on dmem_array.

Test Plan:
- Store/load: write 64'hDEAD_BEEF_0000_0010 to addr 0x18, then load 0x18 -> DM_readData=64'hDEAD_BEEF_0000_0010. Load 0x1B (misaligned) -> same value.
- Out of range: store 64'h1 to addr 0x200 (widx 64) -> no word changes. Load 0x200 -> 0.
- Full dump, ready held high: preload mem[i]=i*3, pulse dump.
  - dump_valid rises 1 cycle after the edge; 64 consecutive beats with index 0..63 and data i*3.
  - dump_done pulses exactly once, the cycle after beat 63; busy falls the cycle after that.
- Backpressure: dump_ready toggled 1,0,0,1,... -> dump_data/dump_index stable across every stalled cycle, no word skipped or duplicated, total 64 beats.
- Store during dump: DM_writeEnable=1 to addr 0x0 with data 64'hFF at beat 10 -> mem[0] unchanged (0 if preloaded 0), wr_dropped=1 persists after dump_done.
- Reset mid-dump: assert reset at beat 20 -> dump_valid=0 and busy=0 asynchronously. After release, load of 0x8 returns 0 and no dump_done was pulsed.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

  localparam int DMEM_N        = 64;
  localparam int DMEM_DEPTH    = 64;
  localparam int DMEM_ADDR_LSB = 3;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } dump_state_t;

  // Word index from a byte address; range checking is left to the caller.
  function automatic logic [DMEM_N-1:0] widx_of(input logic [DMEM_N-1:0] addr,
                                                input int lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: async clear, one write port, two combinational read ports.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int N     = DMEM_N,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dmem_dump_responder.sv
// Processor data-memory responder with a valid/ready dump stream of the whole array.
// state  | meaning
// IDLE   | servicing loads/stores, waiting for a dump rising edge
// STREAM | presenting words 0..DEPTH-1, stores blocked
// DONE   | one-cycle dump_done pulse, stores blocked
module dmem_dump_responder
  import dmem_pkg::*;
#(
  parameter int N        = DMEM_N,
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int ADDR_LSB = DMEM_ADDR_LSB
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [N-1:0]             DM_addr,
  input  logic [N-1:0]             DM_writeData,
  input  logic                     DM_writeEnable,
  input  logic                     DM_readEnable,
  output logic [N-1:0]             DM_readData,
  input  logic                     dump,
  output logic [N-1:0]             dump_data,
  output logic [$clog2(DEPTH)-1:0] dump_index,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic                     dump_done,
  output logic                     busy,
  output logic                     wr_dropped
);

  localparam int AW = $clog2(DEPTH);

  dump_state_t   state;
  logic          dump_q;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_next;
  logic [N-1:0]  widx;
  logic          in_range;
  logic          we;
  logic [AW-1:0] raddr_b;
  logic [N-1:0]  rdata_a;
  logic [N-1:0]  rdata_b;

  assign widx     = widx_of(DM_addr, ADDR_LSB);
  assign in_range = widx < N'(DEPTH);
  assign we       = DM_writeEnable && in_range && (state == IDLE);
  assign ptr_next = ptr + 1'b1;
  // Port b pre-fetches the word that the next handshake will present.
  assign raddr_b  = (state == STREAM) ? ptr_next : '0;

  assign DM_readData = (DM_readEnable && in_range) ? rdata_a : '0;

  dmem_array #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (CLOCK_50),
    .rst_n   (reset),
    .we      (we),
    .waddr   (widx[AW-1:0]),
    .wdata   (DM_writeData),
    .raddr_a (widx[AW-1:0]),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dump_q     <= 1'b0;
      ptr        <= '0;
      dump_data  <= '0;
      dump_index <= '0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      busy       <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      dump_q    <= dump;
      dump_done <= 1'b0;
      if (DM_writeEnable && state != IDLE) wr_dropped <= 1'b1;
      case (state)
        IDLE: begin
          if (dump && !dump_q) begin
            ptr        <= '0;
            dump_data  <= rdata_b;
            dump_index <= '0;
            dump_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (dump_valid && dump_ready) begin
            if (ptr == AW'(DEPTH - 1)) begin
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
              state      <= DONE;
            end else begin
              ptr        <= ptr_next;
              dump_data  <= rdata_b;
              dump_index <= ptr_next;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_responder.sv
// Directed bench for dmem_dump_responder: loads/stores, address decode, dump stream and reset.
module tb_dmem_dump_responder;

  logic        CLOCK_50;
  logic        reset;
  logic [63:0] DM_addr;
  logic [63:0] DM_writeData;
  logic        DM_writeEnable;
  logic        DM_readEnable;
  logic [63:0] DM_readData;
  logic        dump;
  logic [63:0] dump_data;
  logic [5:0]  dump_index;
  logic        dump_valid;
  logic        dump_ready;
  logic        dump_done;
  logic        busy;
  logic        wr_dropped;

  int n_checks = 0;
  int n_errors = 0;

  dmem_dump_responder dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .dump           (dump),
    .dump_data      (dump_data),
    .dump_index     (dump_index),
    .dump_valid     (dump_valid),
    .dump_ready     (dump_ready),
    .dump_done      (dump_done),
    .busy           (busy),
    .wr_dropped     (wr_dropped)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic store(input logic [63:0] addr, input logic [63:0] data);
    DM_addr        = addr;
    DM_writeData   = data;
    DM_writeEnable = 1'b1;
    tick();
    DM_writeEnable = 1'b0;
  endtask

  logic pat [4];
  int   exp_i;
  int   cyc;

  initial begin
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b0; DM_addr = '0; DM_writeData = '0; DM_writeEnable = 1'b0;
    DM_readEnable = 1'b0; dump = 1'b0; dump_ready = 1'b0;
    #12;
    check("rst_valid", dump_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", dump_done, 0);
    check("rst_dropped", wr_dropped, 0);
    check("rst_index", dump_index, 0);
    check("rst_data", dump_data, 0);
    reset = 1'b1;
    tick();

    // store/load, misaligned load, read enable gating
    store(64'h18, 64'hDEAD_BEEF_0000_0010);
    DM_readEnable = 1'b1; DM_addr = 64'h18; #1;
    check("load_18", DM_readData, 64'hDEAD_BEEF_0000_0010);
    DM_addr = 64'h1B; #1;
    check("load_1b", DM_readData, 64'hDEAD_BEEF_0000_0010);
    DM_readEnable = 1'b0; #1;
    check("load_noen", DM_readData, 0);

    // same-cycle load and store: old value before the edge, new value after
    DM_readEnable = 1'b1; DM_addr = 64'h18; DM_writeData = 64'h1234; DM_writeEnable = 1'b1; #1;
    check("rw_old", DM_readData, 64'hDEAD_BEEF_0000_0010);
    tick();
    DM_writeEnable = 1'b0; #1;
    check("rw_new", DM_readData, 64'h1234);

    // out of range store must not alias onto word 0
    store(64'h200, 64'h1);
    DM_addr = 64'h200; #1;
    check("load_oor", DM_readData, 0);
    DM_addr = 64'h0; #1;
    check("oor_no_alias", DM_readData, 0);

    for (int i = 0; i < 64; i++) store(64'(i * 8), 64'(i * 3));
    DM_addr = 64'h10; #1;
    check("preload_2", DM_readData, 6);

    // full dump with ready held high
    dump_ready = 1'b1;
    dump = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      check("full_valid", dump_valid, 1);
      check("full_index", dump_index, 64'(i));
      check("full_data", dump_data, 64'(i * 3));
      check("full_busy", busy, 1);
      check("full_nodone", dump_done, 0);
      if (i == 5) check("load_in_dump", DM_readData, 6);
      tick();
    end
    check("full_done", dump_done, 1);
    check("full_done_busy", busy, 1);
    check("full_done_valid", dump_valid, 0);
    tick();
    check("full_done_once", dump_done, 0);
    check("full_busy_fall", busy, 0);
    tick();
    check("no_retrigger", dump_valid, 0);
    check("no_drop_yet", wr_dropped, 0);

    // backpressure with a store attempted at beat 10
    dump = 1'b0;
    tick();
    dump = 1'b1;
    tick();
    exp_i = 0;
    cyc = 0;
    DM_addr = 64'h0;
    DM_writeData = 64'hFF;
    while (exp_i < 64 && cyc < 400) begin
      dump_ready = pat[cyc % 4];
      DM_writeEnable = (exp_i == 10);
      #1;
      check("bp_valid", dump_valid, 1);
      check("bp_index", dump_index, 64'(exp_i));
      check("bp_data", dump_data, 64'(exp_i * 3));
      tick();
      if (dump_ready) exp_i++;
      cyc++;
    end
    DM_writeEnable = 1'b0;
    dump_ready = 1'b1;
    check("bp_beats", 64'(exp_i), 64);
    check("bp_done", dump_done, 1);
    tick();
    check("bp_busy_fall", busy, 0);
    DM_addr = 64'h0; #1;
    check("blocked_store", DM_readData, 0);
    check("dropped_sticky", wr_dropped, 1);

    // reset in the middle of a dump
    dump = 1'b0;
    tick();
    dump = 1'b1;
    tick();
    repeat (20) tick();
    check("mid_index", dump_index, 20);
    reset = 1'b0;
    #1;
    check("arst_valid", dump_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_dropped", wr_dropped, 0);
    #3;
    reset = 1'b1;
    dump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_nodone", dump_done, 0);
      check("arst_idle", dump_valid, 0);
    end
    DM_addr = 64'h8; #1;
    check("arst_cleared", DM_readData, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
